// File: rtl/wave_shape_classifier.sv
// Windowed mean-square accumulator with a restoring divider producing the crest ratio Vpp^2/MS (Q4.4).
// Optional macro WAVE_CLASS_HYST_EN: wave_type only changes after two consecutive identical classifications.
module wave_shape_classifier #(
    parameter int DATA_W   = 8,
    parameter int LOG2_N   = 6,
    parameter int MIN_VPP  = 8,
    parameter int SQR_TOL  = 16,
    parameter int SINE_TOL = 16,
    parameter int TRI_TOL  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0]        vpp,
    output logic                     result_valid,
    output logic [1:0]               wave_type,
    output logic [7:0]               papr,
    output logic [2*DATA_W-1:0]      ms,
    output logic                     overrun
);

    localparam int SQ_W   = 2 * DATA_W;
    localparam int ACC_W  = SQ_W + LOG2_N;
    localparam int NUM_W  = SQ_W + 4;
    localparam int ITER_W = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {ACCUM, DIV, CLASS} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LOG2_N-1:0]  cnt;
    logic [SQ_W-1:0]    ms_l;
    logic [DATA_W-1:0]  vpp_l;
    logic               pending;
    logic               skip;
    logic [NUM_W-1:0]   quo;
    logic [SQ_W-1:0]    rem;
    logic [ITER_W-1:0]  iter;
`ifdef WAVE_CLASS_HYST_EN
    logic [1:0]         hist;
`endif

    logic signed [SQ_W-1:0] prod;
    logic [ACC_W-1:0]       acc_sum;
    logic                   window_end;
    logic [SQ_W-1:0]        vpp_sq;
    logic [SQ_W:0]          rem_shift;
    logic                   rem_ge;
    logic [SQ_W-1:0]        rem_next;
    logic [7:0]             papr_now;
    logic [1:0]             class_now;

    function automatic logic near(input logic [7:0] p, input int target, input int tol);
        int diff;
        diff = int'(p) - target;
        return (diff <= tol) && (diff >= -tol);
    endfunction

    assign prod       = SQ_W'(sample) * SQ_W'(sample);
    assign acc_sum    = acc + ACC_W'($unsigned(prod));
    assign window_end = sample_en && (&cnt);
    assign vpp_sq     = SQ_W'(vpp_l) * SQ_W'(vpp_l);

    // The quotient register doubles as the numerator shift register, MSB first.
    assign rem_shift = {rem, quo[NUM_W-1]};
    assign rem_ge    = rem_shift >= {1'b0, ms_l};
    assign rem_next  = rem_ge ? SQ_W'(rem_shift - {1'b0, ms_l}) : rem_shift[SQ_W-1:0];
    assign papr_now  = (|quo[NUM_W-1:8]) ? 8'hFF : quo[7:0];

    always_comb begin
        class_now = 2'b00;
        if (skip)
            class_now = 2'b00;
        else if (near(papr_now, 64, SQR_TOL))
            class_now = 2'b10;
        else if (near(papr_now, 128, SINE_TOL))
            class_now = 2'b01;
        else if (near(papr_now, 192, TRI_TOL))
            class_now = 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            cnt          <= '0;
            ms_l         <= '0;
            vpp_l        <= '0;
            pending      <= 1'b0;
            skip         <= 1'b0;
            quo          <= '0;
            rem          <= '0;
            iter         <= '0;
            result_valid <= 1'b0;
            wave_type    <= 2'b00;
            papr         <= 8'd0;
            ms           <= '0;
            overrun      <= 1'b0;
`ifdef WAVE_CLASS_HYST_EN
            hist         <= 2'b00;
`endif
        end else begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;

            case (state)
                ACCUM: begin
                    if (pending) begin
                        pending <= 1'b0;
                        if ((ms_l != '0) && (vpp_l >= DATA_W'(MIN_VPP))) begin
                            state <= DIV;
                            quo   <= {vpp_sq, 4'b0000};
                            rem   <= '0;
                            iter  <= '0;
                            skip  <= 1'b0;
                        end else begin
                            state <= CLASS;
                            skip  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    quo  <= {quo[NUM_W-2:0], rem_ge};
                    rem  <= rem_next;
                    iter <= iter + ITER_W'(1);
                    if (iter == ITER_W'(NUM_W - 1))
                        state <= CLASS;
                end
                CLASS: begin
                    papr         <= skip ? 8'd0 : papr_now;
                    ms           <= ms_l;
                    result_valid <= 1'b1;
`ifdef WAVE_CLASS_HYST_EN
                    if (class_now == hist)
                        wave_type <= class_now;
                    hist <= class_now;
`else
                    wave_type <= class_now;
`endif
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase

            // Accumulation never stalls; a window ending while busy is dropped but still restarts the count.
            if (sample_en) begin
                if (window_end) begin
                    acc <= '0;
                    cnt <= '0;
                    if (state == ACCUM) begin
                        ms_l    <= SQ_W'(acc_sum >> LOG2_N);
                        vpp_l   <= vpp;
                        pending <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + LOG2_N'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_shape_classifier.sv
// Self-checking bench for wave_shape_classifier: directed and randomized windows against a window-level reference model.
module tb_wave_shape_classifier;

    localparam int DATA_W  = 8;
    localparam int LOG2_N  = 6;
    localparam int N       = 64;
    localparam int MIN_VPP = 8;
    localparam int LAT_DIV = 2 * DATA_W + 4 + 2;
    localparam int LAT_SKP = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                     sample_en, b_sample_en;
    logic signed [DATA_W-1:0] sample, b_sample;
    logic [DATA_W-1:0]        vpp, b_vpp;
    logic                     result_valid, b_result_valid;
    logic [1:0]               wave_type, b_wave_type;
    logic [7:0]               papr, b_papr;
    logic [2*DATA_W-1:0]      ms, b_ms;
    logic                     overrun, b_overrun;

    wave_shape_classifier dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample), .vpp(vpp),
        .result_valid(result_valid), .wave_type(wave_type), .papr(papr), .ms(ms), .overrun(overrun)
    );

    wave_shape_classifier #(.LOG2_N(2)) dut_b (
        .clk(clk), .rst(rst), .sample_en(b_sample_en), .sample(b_sample), .vpp(b_vpp),
        .result_valid(b_result_valid), .wave_type(b_wave_type), .papr(b_papr), .ms(b_ms), .overrun(b_overrun)
    );

    int checks   = 0;
    int failures = 0;

    int win_samples[N];
    int exp_ms, exp_papr, exp_lat, exp_wave;
    int m_hist = 0;
    int m_wave = 0;
    int obs_lat;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: first match of square, sine, triangle within tolerance of its crest-ratio target.
    function automatic int classifyRef(input int p);
        if (absInt(p - 64) <= 16) return 2;
        if (absInt(p - 128) <= 16) return 1;
        if (absInt(p - 192) <= 16) return 3;
        return 0;
    endfunction

    function automatic void modelWindow(input int vpp_val);
        longint sum;
        longint q;
        int cls;
        sum = 0;
        for (int i = 0; i < N; i++) sum += longint'(win_samples[i]) * win_samples[i];
        exp_ms = int'(sum / N);
        if (exp_ms == 0 || vpp_val < MIN_VPP) begin
            exp_papr = 0;
            cls      = 0;
            exp_lat  = LAT_SKP;
        end else begin
            q        = longint'(vpp_val) * vpp_val * 16 / exp_ms;
            exp_papr = (q > 255) ? 255 : int'(q);
            cls      = classifyRef(exp_papr);
            exp_lat  = LAT_DIV;
        end
`ifdef WAVE_CLASS_HYST_EN
        if (cls == m_hist) m_wave = cls;
        m_hist = cls;
`else
        m_wave = cls;
`endif
        exp_wave = m_wave;
    endfunction

    function automatic void fillSine(input int amp, input int phase);
        real x;
        for (int i = 0; i < N; i++) begin
            x = amp * $sin(2.0 * 3.14159265358979 * (i + phase) / N);
            win_samples[i] = $rtoi(x + ((x >= 0.0) ? 0.5 : -0.5));
        end
    endfunction

    function automatic void fillSquare(input int amp);
        for (int i = 0; i < N; i++) win_samples[i] = (i < N / 2) ? amp : -amp;
    endfunction

    function automatic void fillTriangle(input int amp);
        int step;
        step = (2 * amp) / (N / 2);
        for (int i = 0; i < N; i++)
            win_samples[i] = (i < N / 2) ? (-amp + step * i) : (amp - step * (i - N / 2));
    endfunction

    function automatic void fillNoise(input int range);
        for (int i = 0; i < N; i++) win_samples[i] = int'($urandom_range(2 * range, 0)) - range;
    endfunction

    function automatic int peakToPeak();
        int lo, hi;
        lo = win_samples[0];
        hi = win_samples[0];
        for (int i = 1; i < N; i++) begin
            if (win_samples[i] < lo) lo = win_samples[i];
            if (win_samples[i] > hi) hi = win_samples[i];
        end
        return (hi - lo > 255) ? 255 : hi - lo;
    endfunction

    // Ends on the negedge that presents the window's final strobe.
    task automatic applyStimulus(input int gap, input int vpp_val);
        for (int c = 0; c <= (N - 1) * gap; c++) begin
            @(negedge clk);
            sample_en = ((c % gap) == 0);
            sample    = 8'(win_samples[c / gap]);
            vpp       = 8'(vpp_val);
        end
    endtask

    task automatic waitResult();
        int k;
        bit seen;
        k    = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            sample_en = 1'b0;
            k++;
            if (result_valid) seen = 1;
        end
        obs_lat = seen ? k - 1 : 999;
    endtask

    task automatic runWindow(input string tag, input int gap, input int vpp_val);
        modelWindow(vpp_val);
        applyStimulus(gap, vpp_val);
        waitResult();
        checkOutput({tag, "_latency"}, obs_lat, exp_lat);
        checkOutput({tag, "_papr"}, papr, exp_papr);
        checkOutput({tag, "_wave"}, wave_type, exp_wave);
        checkOutput({tag, "_ms"}, ms, exp_ms);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, result_valid, 0);
        checkOutput({tag, "_hold"}, papr, exp_papr);
    endtask

    initial begin
        int b_ovr, b_res, amp, w, kind, gap;
        bit seen;

        rst = 1'b1;
        sample_en = 1'b0; sample = '0; vpp = '0;
        b_sample_en = 1'b0; b_sample = '0; b_vpp = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", result_valid, 0);
        checkOutput("reset_wave", wave_type, 0);
        checkOutput("reset_papr", papr, 0);
        checkOutput("reset_ms", ms, 0);
        checkOutput("reset_overrun", overrun, 0);
        rst = 1'b0;

        $display("[TB] overrun sequence on the 4-sample instance");
        b_ovr = 0;
        b_res = 0;
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            if (b_overrun) b_ovr++;
            if (b_result_valid) begin
                b_res++;
                if (b_res == 1) begin
                    checkOutput("ovr_first_time", c, 26);
                    checkOutput("ovr_first_papr", b_papr, 64);
                    checkOutput("ovr_first_ms", b_ms, 2500);
                end else if (b_res == 2) begin
                    checkOutput("ovr_next_time", c, 50);
                    checkOutput("ovr_next_papr", b_papr, 255);
                    checkOutput("ovr_next_ms", b_ms, 625);
                end
            end
            if (c < 28) begin
                w   = c / 4;
                amp = (w == 0) ? 50 : ((w == 6) ? 25 : 10);
                b_sample_en = 1'b1;
                b_sample    = 8'((c % 2 == 1) ? amp : -amp);
                b_vpp       = 8'((w == 0 || w == 6) ? 100 : 20);
            end else begin
                b_sample_en = 1'b0;
            end
        end
        checkOutput("ovr_pulse_count", b_ovr, 5);
        checkOutput("ovr_result_count", b_res, 2);

        $display("[TB] directed windows");
        fillSine(100, 0);    runWindow("sine1", 4, 200);
        fillSine(100, 7);    runWindow("sine2", 4, 200);
        fillSquare(100);     runWindow("square1", 2, 200);
        fillSquare(100);     runWindow("square2", 1, 200);
        fillTriangle(96);    runWindow("tri1", 3, 192);
        fillTriangle(96);    runWindow("tri2", 1, 192);
        fillSquare(0);       runWindow("zero", 1, 0);
        fillSquare(100);     runWindow("vpp_below_min", 1, MIN_VPP - 1);
        fillSquare(100);     runWindow("vpp_at_min", 1, MIN_VPP);
        fillSquare(10);      runWindow("saturate", 1, 200);
        fillSquare(100);     runWindow("square3", 1, 200);

        $display("[TB] reset during divide");
        fillSquare(100);
        applyStimulus(1, 200);
        repeat (11) @(negedge clk);
        sample_en = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_papr", papr, 0);
        checkOutput("midrst_ms", ms, 0);
        checkOutput("midrst_wave", wave_type, 0);
        @(negedge clk);
        rst = 1'b0;
        m_hist = 0;
        m_wave = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen = 1;
        end
        checkOutput("midrst_no_result", seen, 0);
        fillSquare(100);     runWindow("after_rst", 1, 200);

        $display("[TB] randomized windows");
        for (int r = 0; r < 8; r++) begin
            kind = int'($urandom_range(3, 0));
            gap  = int'($urandom_range(4, 1));
            amp  = int'($urandom_range(120, 40));
            case (kind)
                0: fillSine(amp, int'($urandom_range(63, 0)));
                1: fillSquare(amp);
                2: fillTriangle(16 * int'($urandom_range(7, 3)));
                default: fillNoise(int'($urandom_range(60, 1)));
            endcase
            runWindow($sformatf("rand%0d", r), gap, peakToPeak());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_shape_classifier.md
Name: wave_shape_classifier

Overview:
- Parametrised successor to the sine/square identifier in the MEASURE path.
- Accumulates the mean square of the DC-removed signal over a 2^LOG2_N-sample window and computes the crest ratio PAPR = Vpp²/MS in Q4.4 with a sequential restoring divider.
- Classifies each window as sine, square, triangle or unknown, and issues a one-cycle result strobe to the display/control logic.
- Sample rate comes from an external sample_en strobe; no internal divider.

Parameters:
- DATA_W, 8, width of the signed sample and the unsigned vpp.
- LOG2_N, 6, log2 of the window length (N = 2^LOG2_N samples).
- MIN_VPP, 8, vpp below this value forces UNKNOWN and skips the divide.
- SQR_TOL, 16, Q4.4 tolerance around the square target 64 (4.0).
- SINE_TOL, 16, Q4.4 tolerance around the sine target 128 (8.0).
- TRI_TOL, 16, Q4.4 tolerance around the triangle target 192 (12.0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  one-cycle strobe; sample is valid on this cycle.
- sample  in  DATA_W signed  DC-removed input sample.
- vpp  in  DATA_W unsigned  peak-to-peak of the current window; sampled on the window's final sample_en.
- result_valid  out  1  one-cycle pulse when the outputs below update.
- wave_type  out  2  00 unknown, 01 sine, 10 square, 11 triangle.
- papr  out  8  Vpp²/MS in Q4.4, saturated at 255.
- ms  out  2*DATA_W  mean square of the last window (sum >> LOG2_N).
- overrun  out  1  one-cycle pulse when a window completes while the divider is busy.

Behaviour:
- Reset values: all outputs 0; accumulator 0; sample counter 0; state ACCUM.
- The accumulator is 2*DATA_W+LOG2_N bits wide and never overflows.
- Accumulation runs in every state.
  - On each sample_en: acc += sample*sample (signed product, unsigned result); cnt += 1.
  - On the Nth sample_en (cnt = N-1): latch ms_l = (acc + sample²) >> LOG2_N and vpp_l = vpp; clear acc and cnt in the same cycle so the next window starts immediately.
- FSM states: ACCUM, DIV, CLASS.
  - ACCUM -> DIV on window end when ms_l≠0 and vpp_l≥MIN_VPP.
  - ACCUM -> CLASS directly on window end otherwise; papr is forced to 0 and wave_type to UNKNOWN.
  - DIV: restoring divide of NUM = vpp_l² << 4 (NUM_W = 2*DATA_W+4 bits) by ms_l, one quotient bit per cycle, NUM_W cycles, MSB first.
  - DIV -> CLASS after the last iteration.
  - CLASS: one cycle. papr = (quotient > 255) ? 255 : quotient[7:0].
  - CLASS classification: first match in order square, sine, triangle, where the condition is |papr - target| ≤ tol; no match gives UNKNOWN.
  - CLASS: ms <= ms_l; assert result_valid for exactly this cycle; then return to ACCUM.
- Latency: result_valid rises NUM_W+2 clk edges after the edge that accepts the Nth sample (22 for DATA_W=8). On the skip path it rises after 2 edges.
- Overrun: a window end while in DIV or CLASS pulses overrun and discards that window's latch. The divider keeps its operands, and accumulation of the following window still restarts.
- Outputs hold between result_valid pulses.
- sample_en while the divider is busy is still accumulated; there is no backpressure.
- rst asserted mid-window or mid-divide returns everything to reset values within the same cycle (async). No result_valid is produced for the aborted window.

Optional Feature:
- Macro WAVE_CLASS_HYST_EN.
- Defined:
  - wave_type changes only when two consecutive windows classify identically; otherwise the previous wave_type is held.
  - papr, ms and result_valid still update every window.
  - The hysteresis history resets to UNKNOWN.
- Undefined: wave_type updates on every window; no extra registers.

Test Plan:
- Sine, amplitude 100, 64 samples/period, sample_en every 4 clk, vpp=200 -> MS≈5000, papr 128±4, wave_type=01, result_valid 22 clk after the 64th strobe.
- Square ±100, vpp=200 -> MS=10000, papr=64, wave_type=10.
- Triangle ±96 (32-step ramps), vpp=192 -> MS≈3072, papr 192±6, wave_type=11.
- All-zero input, vpp=0 -> skip path; papr=0, wave_type=00, result_valid 2 clk after window end.
- LOG2_N=2 with sample_en every clk -> overrun pulses on the second window end; first result is still correct; the window after the divide completes is accepted.
- rst pulsed for 1 clk 10 cycles into DIV -> all outputs 0, no result_valid for that window; the next full square window gives papr=64. With WAVE_CLASS_HYST_EN defined, sine then square -> wave_type stays 01 until a second square window.
